// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order FIFO of predicted branches, checked against execute outcomes.
// Optional build macro BRU_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int PW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pred_valid,
   input  logic          pred_taken,
   input  logic [AW-1:0] pred_pc,
   input  logic [AW-1:0] pred_target,
   output logic          pred_ready,
   input  logic          res_valid,
   input  logic          res_taken,
   input  logic [AW-1:0] res_target,
   output logic          upd_valid,
   output logic          upd_x,
   output logic [AW-1:0] upd_pc,
   output logic          flush,
   output logic [AW-1:0] redirect_pc,
`ifdef BRU_STATS_EN
   output logic [15:0]   stat_resolved,
   output logic [15:0]   stat_mispred,
`endif
   output logic          res_err,
   output logic [PW:0]   count
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   typedef struct packed {
      logic          taken;
      logic [AW-1:0] pc;
      logic [AW-1:0] target;
   } entry_t;

   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   state_t          state_q, state_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]     count_q, count_d;
   entry_t          mem_q [DEPTH];
   entry_t          head;
   logic            push, res_ok, mispredict, do_write;

   logic            upd_valid_q, upd_x_q, flush_q, res_err_q;
   logic [AW-1:0]   upd_pc_q, redirect_pc_q;

   assign head       = mem_q[rd_ptr_q];
   assign pred_ready = (state_q == ST_RUN) && (count_q != FULL);
   assign push       = pred_valid && pred_ready;
   assign res_ok     = res_valid && (state_q == ST_RUN) && (count_q != '0);
   assign mispredict = res_ok && ((res_taken != head.taken) ||
                                  (res_taken && head.taken && (res_target != head.target)));

   // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_write = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mispredict) begin
               // Younger branches are on the wrong path; a same-cycle push is dropped with them.
               state_d  = ST_FLUSH;
               rd_ptr_d = '0;
               wr_ptr_d = '0;
               count_d  = '0;
            end else begin
               if (res_ok) rd_ptr_d = rd_ptr_q + PW'(1);
               if (push) begin
                  wr_ptr_d = wr_ptr_q + PW'(1);
                  do_write = 1'b1;
               end
               count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, res_ok};
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         upd_valid_q   <= 1'b0;
         upd_x_q       <= 1'b0;
         upd_pc_q      <= '0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
         res_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         upd_valid_q <= res_ok;
         flush_q     <= mispredict;
         res_err_q   <= res_valid && !res_ok;
         if (res_ok) begin
            upd_x_q  <= res_taken;
            upd_pc_q <= head.pc;
         end
         if (mispredict)
            redirect_pc_q <= res_taken ? res_target : head.pc + AW'(4);
      end
   end

   // NOTE: entry storage is not reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (do_write)
         mem_q[wr_ptr_q] <= '{taken: pred_taken, pc: pred_pc, target: pred_target};
   end

`ifdef BRU_STATS_EN
   logic [15:0] stat_resolved_q, stat_mispred_q;

   // Counters step in the same edge that raises upd_valid/flush, and saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_resolved_q <= '0;
         stat_mispred_q  <= '0;
      end else begin
         if (res_ok && (stat_resolved_q != 16'hFFFF))
            stat_resolved_q <= stat_resolved_q + 16'd1;
         if (mispredict && (stat_mispred_q != 16'hFFFF))
            stat_mispred_q <= stat_mispred_q + 16'd1;
      end
   end

   assign stat_resolved = stat_resolved_q;
   assign stat_mispred  = stat_mispred_q;
`endif

   assign upd_valid   = upd_valid_q;
   assign upd_x       = upd_x_q;
   assign upd_pc      = upd_pc_q;
   assign flush       = flush_q;
   assign redirect_pc = redirect_pc_q;
   assign res_err     = res_err_q;
   assign count       = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random traffic
// against a queue-based model of the in-flight branch list.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int PW    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pred_valid, pred_taken, res_valid, res_taken;
   logic [AW-1:0] pred_pc, pred_target, res_target;
   logic          pred_ready, upd_valid, upd_x, flush, res_err;
   logic [AW-1:0] upd_pc, redirect_pc;
   logic [PW:0]   count;

   branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .upd_valid(upd_valid), .upd_x(upd_x), .upd_pc(upd_pc),
      .flush(flush), .redirect_pc(redirect_pc), .res_err(res_err), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } br_t;

   br_t         q[$];
   logic        m_flush;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of traffic: drive, check pred_ready, predict, clock, check registered outputs.
   task automatic step(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt);
      logic        rdy, acc, resolve, mis, e_uv, e_ux, e_fl, e_err;
      logic [31:0] e_upc, e_redir;
      br_t         h;
      pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptgt;
      res_valid = rv; res_taken = rt; res_target = rtgt;
      #1;
      rdy = !m_flush && (q.size() != DEPTH);
      check("pred_ready", {31'd0, pred_ready}, {31'd0, rdy});
      acc = pv && rdy;
      resolve = rv && !m_flush && (q.size() > 0);
      e_err = rv && !resolve;
      e_uv = 1'b0; e_ux = 1'b0; e_fl = 1'b0; e_upc = '0; e_redir = '0;
      m_flush = 1'b0;
      if (resolve) begin
         h = q[0];
         mis = (rt != h.taken) || (rt && h.taken && (rtgt != h.target));
         e_uv = 1'b1; e_ux = rt; e_upc = h.pc;
         if (mis) begin
            e_fl = 1'b1;
            e_redir = rt ? rtgt : h.pc + 32'd4;
            q.delete();
            m_flush = 1'b1;
         end else begin
            void'(q.pop_front());
         end
      end
      if (acc && !m_flush) q.push_back('{pc: ppc, taken: pt, target: ptgt});
      @(posedge clk);
      @(negedge clk);
      check("upd_valid", {31'd0, upd_valid}, {31'd0, e_uv});
      if (e_uv) begin
         check("upd_x", {31'd0, upd_x}, {31'd0, e_ux});
         check("upd_pc", upd_pc, e_upc);
      end
      check("flush", {31'd0, flush}, {31'd0, e_fl});
      if (e_fl) check("redirect_pc", redirect_pc, e_redir);
      check("res_err", {31'd0, res_err}, {31'd0, e_err});
      check("count", {29'd0, count}, q.size());
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic push(input logic t, input logic [31:0] pc, input logic [31:0] tgt);
      step(1'b1, t, pc, tgt, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic resolve(input logic t, input logic [31:0] tgt);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, t, tgt);
   endtask

   initial begin
      logic        pv, pt, rv, rt;
      logic [31:0] ppc, ptgt, rtgt;
      rst_n = 1'b0;
      pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
      res_valid = 0; res_taken = 0; res_target = 0;
      m_flush = 1'b0;
      #2;
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
      check("rst_upd_x", {31'd0, upd_x}, 32'd0);
      check("rst_upd_pc", upd_pc, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_redirect", redirect_pc, 32'd0);
      check("rst_res_err", {31'd0, res_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ready", {31'd0, pred_ready}, 32'd1);

      // Reset mid-traffic with three entries in flight and an update pulse pending.
      push(1'b1, 32'h10, 32'h20);
      push(1'b0, 32'h14, 32'h0);
      push(1'b1, 32'h18, 32'h28);
      step(1'b1, 1'b0, 32'h1c, 32'h0, 1'b1, 1'b1, 32'h20);
      pred_valid = 0; res_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      q.delete(); m_flush = 1'b0;
      check("mid_rst_count", {29'd0, count}, 32'd0);
      check("mid_rst_flush", {31'd0, flush}, 32'd0);
      check("mid_rst_upd_valid", {31'd0, upd_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", {31'd0, pred_ready}, 32'd1);

      // Correct taken prediction.
      push(1'b1, 32'h100, 32'h200);
      resolve(1'b1, 32'h200);

      // Mispredicted NT head flushes younger entries; one cycle of refused pushes.
      push(1'b0, 32'h100, 32'h0);
      push(1'b1, 32'h104, 32'h180);
      push(1'b1, 32'h108, 32'h188);
      resolve(1'b1, 32'h300);
      push(1'b1, 32'h10c, 32'h190);
      idle();

      // Wrong target, then taken prediction resolved not-taken.
      push(1'b1, 32'h40, 32'h80);
      resolve(1'b1, 32'h90);
      idle();
      push(1'b1, 32'h40, 32'h80);
      resolve(1'b0, 32'h0);
      idle();

      // Fill to DEPTH, push+correct resolve while full, then wrap pointers.
      for (int i = 0; i < DEPTH; i++) push(1'b0, 32'h400 + 32'(4 * i), 32'h0);
      step(1'b1, 1'b1, 32'h4f0, 32'h4f8, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h4f0, 32'h4f8, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++)
         step(1'b1, i[0], 32'h500 + 32'(4 * i), 32'h600 + 32'(4 * i),
              1'b1, q[0].taken, q[0].target);
      while (q.size() > 0) resolve(q[0].taken, q[0].target);

      // Resolution with nothing in flight, with a same-cycle push, and during FLUSH.
      resolve(1'b1, 32'h0);
      step(1'b1, 1'b1, 32'h700, 32'h800, 1'b1, 1'b1, 32'h800);
      resolve(1'b0, 32'h0);
      resolve(1'b1, 32'h0);
      idle();

      // Random traffic with targets from a small pool so matches and mismatches both occur.
      for (int n = 0; n < 400; n++) begin
         pv   = ($urandom_range(0, 99) < 60);
         pt   = $urandom_range(0, 1);
         ppc  = 32'h1000 + 32'(4 * $urandom_range(0, 63));
         ptgt = 32'h2000 + 32'(256 * $urandom_range(0, 1));
         rv   = ($urandom_range(0, 99) < 50);
         if (q.size() > 0 && $urandom_range(0, 99) < 80) begin
            rt   = q[0].taken;
            rtgt = q[0].target;
         end else begin
            rt   = $urandom_range(0, 1);
            rtgt = 32'h2000 + 32'(256 * $urandom_range(0, 1));
         end
         step(pv, pt, ppc, ptgt, rv, rt, rtgt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
